// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop line synchronizer and mid-bit sampling.
// Emits a one-cycle o_valid per good byte or o_ferr per bad stop bit.
module uart_rx #(
    parameter int D = 10,
    parameter int L = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_ferr,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [L-1:0] HALF = L'(D / 2);
    localparam logic [L-1:0] LAST = L'(D - 1);

    state_t     state;
    state_t     state_nxt;
    logic       sync1;
    logic       rx_s;
    logic [L-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] sr;
    logic       half_hit;
    logic       bit_end;
    logic       entering;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= i_data;
            rx_s  <= sync1;
        end
    end

    assign half_hit = (cnt == HALF);
    assign bit_end  = (cnt == LAST);
    assign entering = (state_nxt != state);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (half_hit) state_nxt = rx_s ? IDLE : DATA;
            DATA:      if (bit_end && idx == 3'd7) state_nxt = STOP;
            STOP:      if (bit_end) state_nxt = rx_s ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE);
    end

    // Counter and index restart on every state entry; DATA also rewinds per bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt     <= '0;
            idx     <= 3'd0;
            sr      <= 8'h00;
            o_data  <= 8'h00;
            o_valid <= 1'b0;
            o_ferr  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_ferr  <= 1'b0;
            if (entering || (state == DATA && bit_end))
                cnt <= '0;
            else if (state == START || state == DATA || state == STOP)
                cnt <= cnt + 1'b1;
            if (entering)
                idx <= 3'd0;
            else if (state == DATA && bit_end)
                idx <= idx + 3'd1;
            if (state == DATA && bit_end)
                sr <= {rx_s, sr[7:1]};
            if (state == STOP && bit_end) begin
                if (rx_s) begin
                    o_data  <= sr;
                    o_valid <= 1'b1;
                end else begin
                    o_ferr  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: D=10 instance for framing/reset scenarios,
// D=25 instance for bit-period skew tolerance.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_a = 1'b1;
    logic       line_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       ferr_a, ferr_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int va_cnt = 0, fa_cnt = 0, vb_cnt = 0, fb_cnt = 0;
    int ovl = 0;
    int va_cyc = 0, fall_cyc = 0, rise_cnt = 0;
    logic busy_prev = 1'b0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #10 clk = ~clk;

    uart_rx #(.D(10), .L(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_data(line_a),
        .o_data(data_a), .o_valid(valid_a),
        .o_ferr(ferr_a), .o_busy(busy_a)
    );

    uart_rx #(.D(25), .L(5)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data(line_b),
        .o_data(data_b), .o_valid(valid_b),
        .o_ferr(ferr_b), .o_busy(busy_b)
    );

    always @(negedge clk) begin
        cyc++;
        if (valid_a) begin
            va_cnt++;
            qa.push_back(data_a);
            va_cyc = cyc;
        end
        if (ferr_a) fa_cnt++;
        if (valid_a && ferr_a) ovl++;
        if (valid_b) begin
            vb_cnt++;
            qb.push_back(data_b);
        end
        if (ferr_b) fb_cnt++;
        if (valid_b && ferr_b) ovl++;
        if (busy_prev && !busy_a) fall_cyc = cyc;
        if (!busy_prev && busy_a) rise_cnt++;
        busy_prev = busy_a;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) line_b = v;
        else     line_a = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] b,
                        input int p, input logic stopv);
        drive(sel, 1'b0, p);
        for (int i = 0; i < 8; i++) drive(sel, b[i], p);
        drive(sel, stopv, p);
    endtask

    task automatic clear_mon();
        va_cnt = 0; fa_cnt = 0; vb_cnt = 0; fb_cnt = 0;
        rise_cnt = 0;
        qa.delete();
        qb.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data_a}, 32'h00);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_ferr", {31'd0, ferr_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        rst = 1'b0;
        drive(0, 1'b1, 10);
        clear_mon();

        // Scenario 1: single frame 0x41
        send(0, 8'h41, 10, 1'b1);
        drive(0, 1'b1, 20);
        check("s1_vcount", va_cnt, 1);
        check("s1_data", {24'd0, data_a}, 32'h41);
        check("s1_ferr", fa_cnt, 0);
        check("s1_busy_fall", ((fall_cyc - va_cyc) >= 0 &&
              (fall_cyc - va_cyc) <= 2) ? 32'd1 : 32'd0, 32'd1);
        clear_mon();

        // Scenario 2: back-to-back frames
        send(0, 8'h00, 10, 1'b1);
        send(0, 8'hFF, 10, 1'b1);
        send(0, 8'hA5, 10, 1'b1);
        drive(0, 1'b1, 20);
        check("s2_vcount", va_cnt, 3);
        if (qa.size() == 3) begin
            check("s2_b0", {24'd0, qa[0]}, 32'h00);
            check("s2_b1", {24'd0, qa[1]}, 32'hFF);
            check("s2_b2", {24'd0, qa[2]}, 32'hA5);
        end
        check("s2_ferr", fa_cnt, 0);
        clear_mon();

        // Scenario 3: 3-clock glitch
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 20);
        check("s3_entered_start", rise_cnt, 1);
        check("s3_vcount", va_cnt, 0);
        check("s3_ferr", fa_cnt, 0);
        check("s3_busy", {31'd0, busy_a}, 32'd0);
        clear_mon();

        // Scenario 4: bad stop bit followed by a long break
        send(0, 8'h55, 10, 1'b0);
        drive(0, 1'b0, 290);
        check("s4_busy_held", {31'd0, busy_a}, 32'd1);
        check("s4_ferr_once", fa_cnt, 1);
        drive(0, 1'b1, 10);
        check("s4_busy_low", {31'd0, busy_a}, 32'd0);
        check("s4_ferr_total", fa_cnt, 1);
        check("s4_vcount", va_cnt, 0);
        check("s4_data_kept", {24'd0, data_a}, 32'hA5);
        clear_mon();

        // Scenario 5: reset mid-frame during bit 4 of 0x3C
        drive(0, 1'b0, 10);
        drive(0, 1'b0, 10);
        drive(0, 1'b0, 10);
        drive(0, 1'b1, 10);
        drive(0, 1'b1, 10);
        drive(0, 1'b1, 5);
        rst = 1'b1;
        drive(0, 1'b1, 3);
        check("s5_rst_data", {24'd0, data_a}, 32'h00);
        check("s5_rst_valid", {31'd0, valid_a}, 32'd0);
        check("s5_rst_ferr", {31'd0, ferr_a}, 32'd0);
        check("s5_rst_busy", {31'd0, busy_a}, 32'd0);
        rst = 1'b0;
        drive(0, 1'b1, 30);
        check("s5_no_pulse", va_cnt + fa_cnt, 0);
        send(0, 8'h96, 10, 1'b1);
        drive(0, 1'b1, 20);
        check("s5_vcount", va_cnt, 1);
        check("s5_data", {24'd0, data_a}, 32'h96);
        clear_mon();

        // Scenario 6: skewed line periods on the D=25 instance
        send(1, 8'h41, 24, 1'b1);
        drive(1, 1'b1, 30);
        check("s6_fast_vcount", vb_cnt, 1);
        if (qb.size() == 1) check("s6_fast_data", {24'd0, qb[0]}, 32'h41);
        clear_mon();
        send(1, 8'h41, 26, 1'b1);
        drive(1, 1'b1, 30);
        check("s6_slow_vcount", vb_cnt, 1);
        if (qb.size() == 1) check("s6_slow_data", {24'd0, qb[0]}, 32'h41);
        check("s6_ferr", fb_cnt, 0);

        check("no_overlap", ovl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter D, default 10, meaning clocks per serial bit (legal range 4..2^L-1).
REQ-002 The block SHALL have parameter L, default 4, meaning the bit-timing counter width in bits.
REQ-003 i_clk  input  1  The single clock; all logic SHALL be clocked on its rising edge.
REQ-004 i_rst  input  1  The reset SHALL be synchronous and active-high.
REQ-005 i_data  input  1  The serial line SHALL be asynchronous to i_clk, with idle high.
REQ-006 o_data  output  8  The block SHALL present the last correctly received byte here.
REQ-007 o_valid  output  1  The block SHALL drive a one-cycle pulse when o_data is updated.
REQ-008 o_ferr  output  1  The block SHALL drive a one-cycle pulse on a framing error (stop bit sampled low).
REQ-009 o_busy  output  1  o_busy SHALL be high whenever the FSM is not in IDLE.

Function
REQ-010 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), with no parity.
REQ-011 i_data SHALL pass through a 2-flop synchronizer whose flops reset to 1; all FSM decisions SHALL use the synchronized value (rx_s).
REQ-012 The FSM SHALL have exactly the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 The bit counter (L bits) and the bit index (3 bits) SHALL be cleared on every state entry.
REQ-014 IDLE: when rx_s==0, the FSM SHALL go to START with cnt=0; otherwise it SHALL remain in IDLE.
REQ-015 START: cnt SHALL increment each clock; at cnt==D/2 (integer division), rx_s SHALL be sampled; a 0 SHALL take the FSM to DATA, and a 1 SHALL take it to IDLE (glitch reject, no pulse).
REQ-016 DATA: cnt SHALL count 0..D-1; at cnt==D-1, rx_s SHALL shift into the MSB of the shift register (right shift) and the index SHALL increment; after the 8th sample the FSM SHALL go to STOP.
REQ-017 STOP: at cnt==D-1, rx_s SHALL be sampled; a 1 SHALL cause o_data<=shift register and o_valid=1 on the next cycle, with the FSM going to IDLE.
REQ-018 STOP with a sampled 0 SHALL cause o_ferr=1 for one cycle, leave o_data unchanged, and take the FSM to WAIT_HIGH.
REQ-019 WAIT_HIGH SHALL hold until rx_s==1, then go to IDLE; a held-low line (break) SHALL produce exactly one o_ferr.
REQ-020 o_valid and o_ferr SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-021 A new start bit SHALL be accepted in the cycle immediately after a successful STOP returns the FSM to IDLE (back-to-back frames, no idle gap required).
REQ-022 o_data SHALL hold its value between o_valid pulses; there SHALL be no downstream handshake, and an unread byte SHALL be overwritten.
REQ-023 Data sampling points SHALL be centred: each data/stop sample SHALL fall D/2 + k*D clocks after the synchronized falling edge, k=1..9.

Reset
REQ-024 When i_rst=1, the block SHALL force: state=IDLE, cnt=0, index=0, shift register=0, o_data=8'h00, o_valid=0, o_ferr=0, o_busy=0, and synchronizer flops=1.
REQ-025 Reset SHALL take priority over all other activity, including mid-frame; the partial byte SHALL be discarded with no pulse.
REQ-026 After reset is released, a line already low SHALL be treated as a start edge on the first cycle rx_s==0.

Verification
REQ-027 Scenario 1: with D=10, drive frame 0x41 (100 clocks/frame, 20 clock-unit period) -> exactly one o_valid, o_data==8'h41, o_ferr never high, and o_busy falls within 2 clocks after o_valid.
REQ-028 Scenario 2: drive back-to-back frames 0x00, 0xFF and 0xA5 with no idle gap -> three o_valid pulses carrying the data in order.
REQ-029 Scenario 3: drive a 3-clock low glitch on the idle line -> the FSM returns to IDLE from START, no o_valid or o_ferr, and o_busy returns low.
REQ-030 Scenario 4: drive frame 0x55 with the stop bit forced to 0, then hold the line low 300 clocks before releasing -> exactly one o_ferr, o_data unchanged from the prior value, and o_busy high until the line returns high.
REQ-031 Scenario 5: assert i_rst during bit 4 of frame 0x3C, then send 0x96 -> all outputs at reset values and exactly one o_valid with o_data==8'h96.
REQ-032 Scenario 6: run frame 0x41 with ±4% bit-period skew (D=25 with line periods of 24 and 26 clocks) -> o_data==8'h41 in both cases.
